// File: rtl/mrd_wrback_banks.sv
// Write-back steering for the 7-bank mixed-radix DFT memory: routes up to 5 butterfly lanes per
// beat to bank write ports, tracks per-stage beat count and raises wr_end on the last write.
module mrd_wrback_banks #(
    parameter int unsigned wADDR = 10,
    parameter int unsigned wDATA = 30
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [11:0]                 expected_cnt_i,
    input  logic [2:0]                  factor_i,
    input  logic                        in_valid_i,
    input  logic [0:4][2:0]             in_bank_index_i,
    input  logic [0:4][wADDR-1:0]       in_bank_addr_i,
    input  logic [0:4][wDATA-1:0]       in_real_i,
    input  logic [0:4][wDATA-1:0]       in_imag_i,
    output logic [0:6]                  wren_o,
    output logic [0:6][wADDR-1:0]       wraddr_o,
    output logic [0:6][wDATA-1:0]       wr_real_o,
    output logic [0:6][wDATA-1:0]       wr_imag_o,
    output logic                        busy_o,
    output logic                        wr_end_o,
    output logic [1:0]                  err_o
);

    typedef enum logic [1:0] {StIdle, StWr, StDone} state_e;

    state_e                 state_q;
    logic [11:0]            cnt_q;
    logic [11:0]            exp_q;
    logic                   busy_q;
    logic                   wr_end_q;
    logic [1:0]             err_q;

    logic [0:6]             wren_d, wren_q;
    logic [0:6][wADDR-1:0]  wraddr_d, wraddr_q;
    logic [0:6][wDATA-1:0]  wr_real_d, wr_real_q;
    logic [0:6][wDATA-1:0]  wr_imag_d, wr_imag_q;

    logic [0:4]             lane_vld;
    logic                   coll;
    logic                   stray;

    always_comb begin
        wren_d    = '0;
        wraddr_d  = '0;
        wr_real_d = '0;
        wr_imag_d = '0;
        coll      = 1'b0;
        stray     = in_valid_i && (state_q != StWr);
        for (int k = 0; k < 5; k++) begin
            lane_vld[k] = in_valid_i && (state_q == StWr) && (3'(k) < factor_i)
                          && (in_bank_index_i[k] != 3'd7);
        end
        // Walk from the highest lane down so the lowest-numbered lane wins a shared bank.
        for (int k = 4; k >= 0; k--) begin
            if (lane_vld[k]) begin
                wren_d[in_bank_index_i[k]]    = 1'b1;
                wraddr_d[in_bank_index_i[k]]  = in_bank_addr_i[k];
                wr_real_d[in_bank_index_i[k]] = in_real_i[k];
                wr_imag_d[in_bank_index_i[k]] = in_imag_i[k];
            end
        end
        for (int k = 1; k < 5; k++) begin
            for (int j = 0; j < k; j++) begin
                if (lane_vld[k] && lane_vld[j] && (in_bank_index_i[k] == in_bank_index_i[j])) begin
                    coll = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            exp_q     <= '0;
            busy_q    <= 1'b0;
            wr_end_q  <= 1'b0;
            err_q     <= '0;
            wren_q    <= '0;
            wraddr_q  <= '0;
            wr_real_q <= '0;
            wr_imag_q <= '0;
        end else begin
            wren_q    <= wren_d;
            wraddr_q  <= wraddr_d;
            wr_real_q <= wr_real_d;
            wr_imag_q <= wr_imag_d;
            wr_end_q  <= 1'b0;
            err_q     <= err_q | {stray, coll};
            if (start_i) begin
                // A start in WR/DONE abandons the running stage without a wr_end.
                cnt_q  <= '0;
                exp_q  <= expected_cnt_i;
                err_q  <= '0;
                busy_q <= 1'b1;
                if (state_q == StIdle && expected_cnt_i == 12'd0) begin
                    state_q  <= StDone;
                    wr_end_q <= 1'b1;
                end else begin
                    state_q <= StWr;
                end
            end else begin
                unique case (state_q)
                    StIdle: busy_q <= 1'b0;
                    StWr: begin
                        if (in_valid_i) begin
                            cnt_q <= cnt_q + 12'd1;
                            if (cnt_q == exp_q - 12'd1) begin
                                state_q  <= StDone;
                                wr_end_q <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign wren_o    = wren_q;
    assign wraddr_o  = wraddr_q;
    assign wr_real_o = wr_real_q;
    assign wr_imag_o = wr_imag_q;
    assign busy_o    = busy_q;
    assign wr_end_o  = wr_end_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_mrd_wrback_banks.sv
// Directed vector bench for mrd_wrback_banks: table of beats with hand-computed bank outputs,
// plus a reset-mid-stage sequence.
module tb_mrd_wrback_banks;

    localparam int unsigned wADDR = 10;
    localparam int unsigned wDATA = 30;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic [11:0]                expected_cnt;
    logic [2:0]                 factor;
    logic                       in_valid;
    logic [0:4][2:0]            in_bank_index;
    logic [0:4][wADDR-1:0]      in_bank_addr;
    logic [0:4][wDATA-1:0]      in_real;
    logic [0:4][wDATA-1:0]      in_imag;
    logic [0:6]                 wren;
    logic [0:6][wADDR-1:0]      wraddr;
    logic [0:6][wDATA-1:0]      wr_real;
    logic [0:6][wDATA-1:0]      wr_imag;
    logic                       busy;
    logic                       wr_end;
    logic [1:0]                 err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mrd_wrback_banks #(.wADDR(wADDR), .wDATA(wDATA)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .expected_cnt_i  (expected_cnt),
        .factor_i        (factor),
        .in_valid_i      (in_valid),
        .in_bank_index_i (in_bank_index),
        .in_bank_addr_i  (in_bank_addr),
        .in_real_i       (in_real),
        .in_imag_i       (in_imag),
        .wren_o          (wren),
        .wraddr_o        (wraddr),
        .wr_real_o       (wr_real),
        .wr_imag_o       (wr_imag),
        .busy_o          (busy),
        .wr_end_o        (wr_end),
        .err_o           (err)
    );

    // Lane data is a fixed function of its address so expected bank data can be recomputed.
    function automatic logic [wDATA-1:0] re_of(int a);
        return wDATA'(a * 7 + 1);
    endfunction
    function automatic logic [wDATA-1:0] im_of(int a);
        return wDATA'(32'h3FFF_FFFF - a);
    endfunction

    typedef struct packed {
        logic        start;
        logic [11:0] exp_cnt;
        logic [2:0]  fac;
        logic        vld;
        logic [14:0] idx;      // lane0 in MSBs
        logic [9:0]  base;     // lane k address = base + k
        logic [6:0]  x_wren;   // bank0 in MSB
        logic [20:0] x_win;    // winning lane per bank, bank0 in MSBs, 7 = none
        logic        x_busy;
        logic        x_wr_end;
        logic [1:0]  x_err;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input int row, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, got, want);
        end
    endtask

    task automatic drive_idle();
        start        = 1'b0;
        in_valid     = 1'b0;
        factor       = 3'd5;
        expected_cnt = 12'd0;
        in_bank_index = '1;
        in_bank_addr = '0;
        in_real      = '0;
        in_imag      = '0;
    endtask

    task automatic drive_beat(input logic [2:0] fac, input logic [14:0] idx, input int base);
        in_valid      = 1'b1;
        factor        = fac;
        in_bank_index = idx;
        for (int k = 0; k < 5; k++) begin
            in_bank_addr[k] = wADDR'(base + k);
            in_real[k]      = re_of(base + k);
            in_imag[k]      = im_of(base + k);
        end
    endtask

    task automatic check_outputs(input int row, input logic [6:0] x_wren, input logic [20:0] x_win,
                                 input logic [9:0] base, input logic x_busy, input logic x_wr_end,
                                 input logic [1:0] x_err);
        logic [2:0] l;
        chk("wren", row, 64'(wren), 64'(x_wren));
        chk("busy", row, 64'(busy), 64'(x_busy));
        chk("wr_end", row, 64'(wr_end), 64'(x_wr_end));
        chk("err", row, 64'(err), 64'(x_err));
        for (int b = 0; b < 7; b++) begin
            l = x_win[(6 - b) * 3 +: 3];
            if (l == 3'd7) begin
                chk("wraddr_idle", row, 64'(wraddr[b]), 64'd0);
                chk("wr_real_idle", row, 64'(wr_real[b]), 64'd0);
            end else begin
                chk("wraddr", row, 64'(wraddr[b]), 64'(int'(base) + int'(l)));
                chk("wr_real", row, 64'(wr_real[b]), 64'(re_of(int'(base) + int'(l))));
                chk("wr_imag", row, 64'(wr_imag[b]), 64'(im_of(int'(base) + int'(l))));
            end
        end
    endtask

    initial begin
        //                start exp  fac  vld  idx(lane0..4)                         base
        //                wren        win(bank0..6)                                   busy end err
        vecs[0]  = '{1'b1, 12'd3, 3'd5, 1'b0, {3'd7,3'd7,3'd7,3'd7,3'd7}, 10'd0,
                     7'b0000000, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7}, 1'b1, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 12'd3, 3'd5, 1'b1, {3'd0,3'd1,3'd2,3'd3,3'd4}, 10'd10,
                     7'b1111100, {3'd0,3'd1,3'd2,3'd3,3'd4,3'd7,3'd7}, 1'b1, 1'b0, 2'b00};
        vecs[2]  = '{1'b0, 12'd3, 3'd5, 1'b0, {3'd7,3'd7,3'd7,3'd7,3'd7}, 10'd0,
                     7'b0000000, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7}, 1'b1, 1'b0, 2'b00};
        vecs[3]  = '{1'b0, 12'd3, 3'd3, 1'b1, {3'd2,3'd0,3'd1,3'd5,3'd6}, 10'd20,
                     7'b1110000, {3'd1,3'd2,3'd0,3'd7,3'd7,3'd7,3'd7}, 1'b1, 1'b0, 2'b00};
        vecs[4]  = '{1'b0, 12'd3, 3'd5, 1'b0, {3'd7,3'd7,3'd7,3'd7,3'd7}, 10'd0,
                     7'b0000000, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7}, 1'b1, 1'b0, 2'b00};
        vecs[5]  = '{1'b0, 12'd3, 3'd5, 1'b1, {3'd0,3'd4,3'd1,3'd4,3'd7}, 10'd30,
                     7'b1100100, {3'd0,3'd2,3'd7,3'd7,3'd1,3'd7,3'd7}, 1'b1, 1'b1, 2'b01};
        vecs[6]  = '{1'b0, 12'd3, 3'd5, 1'b0, {3'd7,3'd7,3'd7,3'd7,3'd7}, 10'd0,
                     7'b0000000, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7}, 1'b0, 1'b0, 2'b01};
        vecs[7]  = '{1'b0, 12'd3, 3'd5, 1'b1, {3'd0,3'd1,3'd2,3'd3,3'd4}, 10'd50,
                     7'b0000000, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7}, 1'b0, 1'b0, 2'b11};
        vecs[8]  = '{1'b1, 12'd0, 3'd5, 1'b0, {3'd7,3'd7,3'd7,3'd7,3'd7}, 10'd0,
                     7'b0000000, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7}, 1'b1, 1'b1, 2'b00};
        vecs[9]  = '{1'b0, 12'd0, 3'd5, 1'b0, {3'd7,3'd7,3'd7,3'd7,3'd7}, 10'd0,
                     7'b0000000, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7}, 1'b0, 1'b0, 2'b00};
        vecs[10] = '{1'b1, 12'd2, 3'd5, 1'b0, {3'd7,3'd7,3'd7,3'd7,3'd7}, 10'd0,
                     7'b0000000, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7}, 1'b1, 1'b0, 2'b00};
        vecs[11] = '{1'b0, 12'd2, 3'd2, 1'b1, {3'd6,3'd6,3'd0,3'd0,3'd0}, 10'd60,
                     7'b0000001, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd0}, 1'b1, 1'b0, 2'b01};
        // Abort: restart with a 1-beat stage; the old stage never reports wr_end.
        vecs[12] = '{1'b1, 12'd1, 3'd5, 1'b0, {3'd7,3'd7,3'd7,3'd7,3'd7}, 10'd0,
                     7'b0000000, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7}, 1'b1, 1'b0, 2'b00};
        vecs[13] = '{1'b0, 12'd1, 3'd4, 1'b1, {3'd3,3'd7,3'd5,3'd7,3'd1}, 10'd70,
                     7'b0001010, {3'd7,3'd7,3'd7,3'd0,3'd7,3'd2,3'd7}, 1'b1, 1'b1, 2'b00};
        vecs[14] = '{1'b0, 12'd1, 3'd5, 1'b0, {3'd7,3'd7,3'd7,3'd7,3'd7}, 10'd0,
                     7'b0000000, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7}, 1'b0, 1'b0, 2'b00};

        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check_outputs(100, 7'b0, {7{3'd7}}, 10'd0, 1'b0, 1'b0, 2'b00);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive_idle();
            start        = vecs[i].start;
            expected_cnt = vecs[i].exp_cnt;
            if (vecs[i].vld) drive_beat(vecs[i].fac, vecs[i].idx, int'(vecs[i].base));
            else factor = vecs[i].fac;
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i].x_wren, vecs[i].x_win, vecs[i].base, vecs[i].x_busy,
                          vecs[i].x_wr_end, vecs[i].x_err);
        end

        // Reset after 2 of 5 beats: the third beat is dropped and no wr_end appears.
        @(negedge clk);
        drive_idle();
        start        = 1'b1;
        expected_cnt = 12'd5;
        @(negedge clk);
        drive_idle();
        drive_beat(3'd5, {3'd0,3'd1,3'd2,3'd3,3'd4}, 80);
        @(negedge clk);
        drive_beat(3'd5, {3'd4,3'd3,3'd2,3'd1,3'd0}, 90);
        @(posedge clk);
        #1;
        check_outputs(200, 7'b1111100, {3'd4,3'd3,3'd2,3'd1,3'd0,3'd7,3'd7}, 10'd90, 1'b1, 1'b0,
                      2'b00);
        @(negedge clk);
        rst_n = 1'b0;
        drive_beat(3'd5, {3'd6,3'd5,3'd0,3'd1,3'd2}, 100);
        @(posedge clk);
        #1;
        check_outputs(201, 7'b0, {7{3'd7}}, 10'd0, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_outputs(202 + i, 7'b0, {7{3'd7}}, 10'd0, 1'b0, 1'b0, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
